// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared widths, state encoding and state decode helpers for the program loader
//
// Contents:
//   ADDR_W, DATA_W, NIB_W, HDR_NIBBLES  datapath widths and header length
//   state_t                             loader state encoding
//   is_ready_state / is_busy_state      output decodes applied to the next state

package prog_loader_pkg;

    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 8;
    localparam int NIB_W       = 4;
    localparam int HDR_NIBBLES = 3;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_HDR     = 4'd1,
        ST_DATA_HI = 4'd2,
        ST_DATA_LO = 4'd3,
        ST_WRITE   = 4'd4,
        ST_CHK_HI  = 4'd5,
        ST_CHK_LO  = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
    } state_t;

    // States in which the loader consumes a nibble from the stream.
    function automatic logic is_ready_state(state_t s);
        return (s == ST_HDR)     || (s == ST_DATA_HI) || (s == ST_DATA_LO) ||
               (s == ST_CHK_HI)  || (s == ST_CHK_LO);
    endfunction

    // A session is in progress from the header through the checksum, WRITE included.
    function automatic logic is_busy_state(state_t s);
        return is_ready_state(s) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - nibble stream and program-memory write bus bundle
//
// Signals:
//   nib_data, nib_valid, nib_ready  nibble stream (source -> loader, ready back)
//   mem_addr, mem_wdata, mem_we     program-memory write port (loader -> memory)
// Modports:
//   master  host side: drives the nibble stream, observes the memory writes
//   slave   loader side: consumes nibbles, drives the memory writes

interface prog_loader_if;
    import prog_loader_pkg::*;

    logic [NIB_W-1:0]  nib_data;
    logic              nib_valid;
    logic              nib_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;

    modport master (
        output nib_data,
        output nib_valid,
        input  nib_ready,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we
    );

    modport slave (
        input  nib_data,
        input  nib_valid,
        output nib_ready,
        output mem_addr,
        output mem_wdata,
        output mem_we
    );

endinterface

// File: rtl/nib_assembler.sv
// rtl/nib_assembler.sv - shift register that assembles accepted nibbles MSB-first into a W-bit word
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset (word -> 0)
//   clear       synchronous clear, wins over load
//   load        shift nib in at the bottom, older nibbles move up
//   nib         incoming nibble
//   word        assembled word

module nib_assembler
    import prog_loader_pkg::*;
#(
    parameter int W = ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [NIB_W-1:0] nib,
    output logic [W-1:0]     word
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word <= '0;
        end else if (clear) begin
            word <= '0;
        end else if (load) begin
            word <= {word[W-NIB_W-1:0], nib};
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a nibble-serial program image into program memory and releases the core
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start        one-cycle pulse; starts a session from IDLE, DONE or ERR
//   bus          nibble stream in, program-memory write port out (slave side)
//   cpu_hold     keeps the core in reset everywhere except DONE
//   busy         session in progress (HDR through CHK_LO)
//   done         image loaded with a matching checksum
//   error        image loaded with a mismatching checksum
//
// Stream format: 3 header nibbles giving LAST = byte count - 1, then two
// nibbles per byte (high first), then a two-nibble checksum (high first).

module prog_loader
    import prog_loader_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    prog_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam logic [1:0] HDR_LAST_CNT = 2'(HDR_NIBBLES - 1);

    state_t            state;
    state_t            state_next;
    logic              take;
    logic              session_start;
    logic              hdr_load;
    logic              data_load;
    logic [1:0]        hdr_cnt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] last;
    logic [DATA_W-1:0] csum;
    logic [DATA_W-1:0] data_word;
    logic [DATA_W-1:0] byte_now;
    logic              unused_data_hi;

    assign take = bus.nib_valid & bus.nib_ready;

    // The byte completes on the edge that accepts its low nibble, so it is
    // formed from the stored high nibble plus the nibble on the bus; this is
    // what gives the one-cycle latency to mem_we and lets CHK_LO decide at once.
    assign byte_now = {data_word[NIB_W-1:0], bus.nib_data};

    // Only the most recent nibble of the data shifter is ever needed.
    assign unused_data_hi = ^data_word[DATA_W-1:NIB_W];

    nib_assembler #(.W(ADDR_W)) u_hdr_asm (
        .clk   (clk),
        .reset (reset),
        .clear (session_start),
        .load  (hdr_load),
        .nib   (bus.nib_data),
        .word  (last)
    );

    nib_assembler #(.W(DATA_W)) u_data_asm (
        .clk   (clk),
        .reset (reset),
        .clear (session_start),
        .load  (data_load),
        .nib   (bus.nib_data),
        .word  (data_word)
    );

    always_comb begin
        state_next    = state;
        session_start = 1'b0;
        hdr_load      = 1'b0;
        data_load     = 1'b0;

        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    session_start = 1'b1;
                    state_next    = ST_HDR;
                end
            end
            ST_HDR: begin
                hdr_load = take;
                if (take && (hdr_cnt == HDR_LAST_CNT)) begin
                    state_next = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                data_load = take;
                if (take) begin
                    state_next = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                data_load = take;
                if (take) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // addr stays at LAST so it never wraps past the final byte
                state_next = (addr == last) ? ST_CHK_HI : ST_DATA_HI;
            end
            ST_CHK_HI: begin
                data_load = take;
                if (take) begin
                    state_next = ST_CHK_LO;
                end
            end
            ST_CHK_LO: begin
                data_load = take;
                if (take) begin
                    state_next = (byte_now == csum) ? ST_DONE : ST_ERR;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Status and handshake outputs are registered from the next state, so
    // each one reflects the current state with no decode after the flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            hdr_cnt       <= '0;
            addr          <= '0;
            csum          <= '0;
            bus.nib_ready <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_hold      <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state <= state_next;

            if (session_start) begin
                hdr_cnt <= '0;
            end else if (hdr_load) begin
                hdr_cnt <= hdr_cnt + 2'd1;
            end

            if (session_start) begin
                addr <= '0;
            end else if ((state == ST_WRITE) && (addr != last)) begin
                addr <= addr + 12'd1;
            end

            if (session_start) begin
                csum <= '0;
            end else if (state == ST_WRITE) begin
                csum <= csum + bus.mem_wdata;
            end

            bus.mem_we <= (state_next == ST_WRITE);
            if (state_next == ST_WRITE) begin
                bus.mem_addr  <= addr;
                bus.mem_wdata <= byte_now;
            end

            bus.nib_ready <= is_ready_state(state_next);
            busy          <= is_busy_state(state_next);
            done          <= (state_next == ST_DONE);
            error         <= (state_next == ST_ERR);
            cpu_hold      <= (state_next != ST_DONE);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized and directed self-checking bench for prog_loader

module tb_prog_loader;
    import prog_loader_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_hold;
    logic busy;
    logic done;
    logic error;

    prog_loader_if bus();

    prog_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus.slave),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference image for the current session and the observed write log.
    logic [7:0] exp_data[$];
    int         log_addr[$];
    int         log_data[$];
    int         ready_in_write = 0;
    int         timeouts       = 0;
    bit         use_gaps       = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            log_addr.push_back(int'(bus.mem_addr));
            log_data.push_back(int'(bus.mem_wdata));
            if (bus.nib_ready !== 1'b0) begin
                ready_in_write++;
            end
        end
    end

    // Entered and left at a falling edge. nib_valid is left high with the
    // nibble just taken; the next call replaces it before the next rising
    // edge, so valid can stay high straight through WRITE.
    task automatic send_nib(input logic [3:0] n);
        logic rdy;
        bit   taken;
        if (use_gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.nib_valid = 1'b0;
                bus.nib_data  = 4'($urandom);
                @(negedge clk);
            end
        end
        bus.nib_valid = 1'b1;
        bus.nib_data  = n;
        taken = 1'b0;
        for (int i = 0; i < 50; i++) begin
            rdy = bus.nib_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) begin
            timeouts++;
        end
    endtask

    task automatic pulse_start();
        bus.nib_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends header + first n_bytes of exp_data; starts a new session.
    task automatic send_front(input int n_bytes, input int start_at);
        logic [11:0] last;
        logic [7:0]  b;
        last = 12'(exp_data.size() - 1);
        log_addr.delete();
        log_data.delete();
        ready_in_write = 0;
        timeouts       = 0;
        pulse_start();
        send_nib(last[11:8]);
        send_nib(last[7:4]);
        send_nib(last[3:0]);
        for (int i = 0; i < n_bytes; i++) begin
            b = exp_data[i];
            send_nib(b[7:4]);
            if (i == start_at) begin
                pulse_start();
            end
            send_nib(b[3:0]);
        end
    endtask

    task automatic run_session(input string tag, input logic [7:0] chk_byte, input int start_at);
        logic [7:0] sum;
        bit         good;
        int         bad_w;
        int         waited;
        sum = 8'h00;
        foreach (exp_data[i]) sum = sum + exp_data[i];
        good = (chk_byte == sum);

        send_front(exp_data.size(), start_at);
        send_nib(chk_byte[7:4]);
        send_nib(chk_byte[3:0]);
        bus.nib_valid = 1'b0;
        waited = 0;
        while (!(done || error) && waited < 20) begin
            @(negedge clk);
            waited++;
        end

        bad_w = 0;
        for (int i = 0; i < log_addr.size() && i < exp_data.size(); i++) begin
            if (log_addr[i] != i || log_data[i] != int'(exp_data[i])) bad_w++;
        end
        chk({tag, "_timeouts"}, 32'(timeouts), 32'd0);
        chk({tag, "_nwrites"}, 32'(log_addr.size()), 32'(exp_data.size()));
        chk({tag, "_write_err"}, 32'(bad_w), 32'd0);
        chk({tag, "_ready_in_write"}, 32'(ready_in_write), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'(good));
        chk({tag, "_error"}, 32'(error), 32'(!good));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!good));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [7:0] image_sum();
        logic [7:0] s;
        s = 8'h00;
        foreach (exp_data[i]) s = s + exp_data[i];
        return s;
    endfunction

    initial begin
        int         n;
        logic [7:0] s;

        reset         = 1'b1;
        start         = 1'b0;
        bus.nib_valid = 1'b0;
        bus.nib_data  = 4'h0;
        #1;
        chk("rst_nib_ready", 32'(bus.nib_ready), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h000);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h00);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic load and its bad-checksum twin.
        exp_data = '{8'h12, 8'h34, 8'h56};
        run_session("basic", 8'h9C, -1);
        run_session("badchk", 8'h9D, -1);

        // start pulse while the loader waits in DATA_LO must be ignored.
        exp_data = '{8'hA5, 8'h3C, 8'h7E, 8'h01};
        run_session("start_mid", image_sum(), 1);

        // Random images with gaps; valid stays high through WRITE when no gap is drawn.
        use_gaps = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, 24);
            exp_data.delete();
            for (int i = 0; i < n; i++) exp_data.push_back(8'($urandom));
            s = image_sum();
            if ($urandom_range(0, 2) == 0) s = s + 8'($urandom_range(1, 255));
            run_session($sformatf("rand%0d", k), s, -1);
        end

        // Reset after the second write abandons the session.
        exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_front(2, -1);
        bus.nib_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_nib_ready", 32'(bus.nib_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("midrst_nwrites", 32'(log_addr.size()), 32'd2);
        reset = 1'b0;
        @(negedge clk);
        exp_data = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55};
        run_session("after_rst", image_sum(), -1);

        // Full address space: 4096 bytes of 0xFF, checksum wraps to 0x00.
        use_gaps = 1'b0;
        exp_data.delete();
        for (int i = 0; i < 4096; i++) exp_data.push_back(8'hFF);
        run_session("full", 8'h00, -1);
        chk("full_last_addr", (log_addr.size() == 4096) ? 32'(log_addr[4095]) : 32'hFFFF_FFFF, 32'hFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
